// File: rtl/my_sum_pkg.sv
// rtl/my_sum_pkg.sv - shared FSM state type and accumulator width helper for my_sum_sched
package my_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Wide enough that summing in_terms values of in_bits each can never overflow.
  function automatic int acc_bits(input int in_bits, input int in_terms);
    return in_bits + $clog2(in_terms);
  endfunction

endpackage

// File: rtl/my_sum_sched_if.sv
// rtl/my_sum_sched_if.sv - operand/result handshake bundle for my_sum_sched (out_sat present with MY_SUM_SCHED_SAT_EN)
interface my_sum_sched_if #(
  parameter int IN_BITS  = 8,
  parameter int IN_TERMS = 4,
  parameter int OUT_BITS = 8
);
  logic signed [IN_BITS-1:0]  in [IN_TERMS];
  logic                       in_valid;
  logic                       in_ready;
  logic signed [OUT_BITS-1:0] out;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
`ifdef MY_SUM_SCHED_SAT_EN
  logic                       out_sat;
`endif

  modport master (
    output in, in_valid, out_ready,
`ifdef MY_SUM_SCHED_SAT_EN
    input  out_sat,
`endif
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  in, in_valid, out_ready,
`ifdef MY_SUM_SCHED_SAT_EN
    output out_sat,
`endif
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/my_sum.sv
// rtl/my_sum.sv - combinational signed summer of in_terms values, sign-extended to out_bits
module my_sum #(
  parameter int in_bits  = 8,
  parameter int in_terms = 2,
  parameter int out_bits = 10
) (
  input  logic signed [in_bits-1:0]  x [in_terms],
  output logic signed [out_bits-1:0] y
);

  always_comb begin
    y = '0;
    for (int i = 0; i < in_terms; i++) begin
      y = y + out_bits'(x[i]);
    end
  end

endmodule

// File: rtl/my_sum_sched.sv
// rtl/my_sum_sched.sv - sums an operand vector CHUNK terms per cycle; MY_SUM_SCHED_SAT_EN selects
// saturating output with out_sat flag, otherwise the result wraps to OUT_BITS.
module my_sum_sched
  import my_sum_pkg::*;
#(
  parameter int IN_BITS  = 8,
  parameter int IN_TERMS = 4,
  parameter int CHUNK    = 2,
  parameter int OUT_BITS = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  my_sum_sched_if.slave  bus
);

  localparam int NCHUNK   = IN_TERMS / CHUNK;
  localparam int ACC_BITS = acc_bits(IN_BITS, IN_TERMS);
  localparam int IDX_BITS = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int W        = (ACC_BITS > OUT_BITS) ? ACC_BITS : OUT_BITS;

  if (IN_TERMS % CHUNK != 0) begin : g_bad_chunk
    $error("my_sum_sched: IN_TERMS must be a multiple of CHUNK");
  end

  state_e                     state_q, state_d;
  logic signed [ACC_BITS-1:0] acc_q, acc_d;
  logic [IDX_BITS-1:0]        idx_q, idx_d;
  logic signed [IN_BITS-1:0]  vec_q [IN_TERMS];
  logic signed [IN_BITS-1:0]  vec_d [IN_TERMS];
  logic signed [IN_BITS-1:0]  chunk [CHUNK];
  logic signed [ACC_BITS-1:0] chunk_sum;

  // Constant-index mux keeps the chunk select free of variable part-selects.
  always_comb begin
    for (int c = 0; c < CHUNK; c++) begin
      chunk[c] = '0;
      for (int k = 0; k < NCHUNK; k++) begin
        if (idx_q == IDX_BITS'(k)) chunk[c] = vec_q[k*CHUNK + c];
      end
    end
  end

  my_sum #(
    .in_bits  (IN_BITS),
    .in_terms (CHUNK),
    .out_bits (ACC_BITS)
  ) u_sum (
    .x (chunk),
    .y (chunk_sum)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    vec_d   = vec_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          vec_d   = bus.in;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = acc_q + chunk_sum;
        idx_d = idx_q + IDX_BITS'(1);
        if (idx_q == IDX_BITS'(NCHUNK - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      for (int i = 0; i < IN_TERMS; i++) vec_q[i] <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
    end
  end

  localparam logic signed [W-1:0] SAT_MAX = {{(W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {{(W-OUT_BITS+1){1'b1}}, {(OUT_BITS-1){1'b0}}};

  logic signed [W-1:0]        acc_ext;
  logic signed [OUT_BITS-1:0] res;
  logic                       clamp;

  always_comb begin
    acc_ext = W'(acc_q);
    clamp   = 1'b0;
    res     = acc_ext[OUT_BITS-1:0];
`ifdef MY_SUM_SCHED_SAT_EN
    if (acc_ext > SAT_MAX) begin
      res   = SAT_MAX[OUT_BITS-1:0];
      clamp = 1'b1;
    end else if (acc_ext < SAT_MIN) begin
      res   = SAT_MIN[OUT_BITS-1:0];
      clamp = 1'b1;
    end
`endif
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out       = (state_q == DONE) ? res : '0;
`ifdef MY_SUM_SCHED_SAT_EN
  assign bus.out_sat   = (state_q == DONE) && clamp;
`else
  logic unused_sat;
  assign unused_sat = clamp ^ SAT_MAX[0] ^ SAT_MIN[0];
`endif

endmodule

// File: tb/tb_my_sum_sched.sv
// tb/tb_my_sum_sched.sv - directed self-checking bench for my_sum_sched (IN_TERMS=4, CHUNK=2, 8-bit)
module tb_my_sum_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  my_sum_sched_if #(.IN_BITS(8), .IN_TERMS(4), .OUT_BITS(8)) bus ();

  my_sum_sched #(
    .IN_BITS  (8),
    .IN_TERMS (4),
    .CHUNK    (2),
    .OUT_BITS (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d);
    bus.in[0] = 8'(a);
    bus.in[1] = 8'(b);
    bus.in[2] = 8'(c);
    bus.in[3] = 8'(d);
  endtask

  // Presents a vector for one edge; caller guarantees the DUT is idle.
  task automatic accept_vec(input int a, input int b, input int c, input int d);
    set_vec(a, b, c, d);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 16) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== 8'sd0) begin
      failures++;
      $display("FAIL reset: in_ready=%b busy=%b out_valid=%b out=%0d, want 1 0 0 0",
               bus.in_ready, bus.busy, bus.out_valid, bus.out);
    end
  endtask

  task automatic test_basic();
    bus.out_ready = 1'b1;
    accept_vec(10, 20, 30, 40);
    set_vec(-1, -1, -1, -1);
    checks++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== 8'sd0) begin
      failures++;
      $display("FAIL basic_accum: busy=%b in_ready=%b out_valid=%b out=%0d, want 1 0 0 0",
               bus.busy, bus.in_ready, bus.out_valid, bus.out);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: out_valid=%b want 0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out !== 8'sd100) begin
      failures++;
      $display("FAIL basic_result: out_valid=%b out=%0d, want 1 100", bus.out_valid, bus.out);
    end
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out !== 8'sd0) begin
      failures++;
      $display("FAIL basic_return_idle: in_ready=%b out_valid=%b out=%0d, want 1 0 0",
               bus.in_ready, bus.out_valid, bus.out);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic signed [7:0] want_pos;
    logic signed [7:0] want_neg;
`ifdef MY_SUM_SCHED_SAT_EN
    want_pos = 8'sd127;
    want_neg = -8'sd128;
`else
    want_pos = -8'sd112;
    want_neg = 8'sd0;
`endif
    bus.out_ready = 1'b1;
    accept_vec(100, 100, 100, 100);
    wait_out(n);
    checks++;
    if (n !== 2 || bus.out !== want_pos) begin
      failures++;
      $display("FAIL overflow_pos: latency=%0d out=%0d, want 2 %0d", n, bus.out, want_pos);
    end
`ifdef MY_SUM_SCHED_SAT_EN
    checks++;
    if (bus.out_sat !== 1'b1) begin
      failures++;
      $display("FAIL overflow_pos_sat: out_sat=%b want 1", bus.out_sat);
    end
`endif
    tick();
    accept_vec(-128, -128, -128, -128);
    wait_out(n);
    checks++;
    if (n !== 2 || bus.out !== want_neg) begin
      failures++;
      $display("FAIL overflow_neg: latency=%0d out=%0d, want 2 %0d", n, bus.out, want_neg);
    end
`ifdef MY_SUM_SCHED_SAT_EN
    checks++;
    if (bus.out_sat !== 1'b1) begin
      failures++;
      $display("FAIL overflow_neg_sat: out_sat=%b want 1", bus.out_sat);
    end
`endif
    tick();
    accept_vec(-5, 3, -7, 1);
    wait_out(n);
    checks++;
    if (n !== 2 || bus.out !== -8'sd8) begin
      failures++;
      $display("FAIL mixed_sign: latency=%0d out=%0d, want 2 -8", n, bus.out);
    end
`ifdef MY_SUM_SCHED_SAT_EN
    checks++;
    if (bus.out_sat !== 1'b0) begin
      failures++;
      $display("FAIL mixed_sign_sat: out_sat=%b want 0", bus.out_sat);
    end
`endif
    tick();
  endtask

  task automatic test_stall();
    int n;
    int bad;
    bus.out_ready = 1'b0;
    accept_vec(1, 1, 1, 1);
    set_vec(5, 5, 5, 5);
    bus.in_valid = 1'b1;
    wait_out(n);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out !== 8'sd4 || bus.in_ready !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (n !== 2 || bad !== 0) begin
      failures++;
      $display("FAIL stall_hold: latency=%0d bad_cycles=%0d, want 2 0", n, bad);
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_release: in_ready=%b busy=%b, want 1 0", bus.in_ready, bus.busy);
    end
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL stall_second_accept: busy=%b want 1", bus.busy);
    end
    wait_out(n);
    checks++;
    if (n !== 2 || bus.out !== 8'sd20) begin
      failures++;
      $display("FAIL stall_second_result: latency=%0d out=%0d, want 2 20", n, bus.out);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int n;
    bus.out_ready = 1'b1;
    accept_vec(7, 7, 7, 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== 8'sd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: out_valid=%b out=%0d in_ready=%b busy=%b, want 0 0 1 0",
               bus.out_valid, bus.out, bus.in_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_no_partial: out_valid=%b want 0", bus.out_valid);
    end
    accept_vec(1, 2, 3, 4);
    wait_out(n);
    checks++;
    if (n !== 2 || bus.out !== 8'sd10) begin
      failures++;
      $display("FAIL reset_mid_after: latency=%0d out=%0d, want 2 10", n, bus.out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    int seen;
    int bad;
    bus.out_ready = 1'b1;
    set_vec(2, 2, 2, 2);
    bus.in_valid = 1'b1;
    first = -1;
    second = -1;
    seen = 0;
    bad = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      tick();
      if (bus.out_valid === 1'b1) begin
        if (bus.out !== 8'sd8) bad++;
        if (seen == 0) first = cyc;
        else if (seen == 1) second = cyc;
        seen++;
      end
    end
    bus.in_valid = 1'b0;
    checks++;
    if (bad !== 0 || first !== 2 || (second - first) !== 4) begin
      failures++;
      $display("FAIL back_to_back: first=%0d spacing=%0d bad=%0d, want 2 4 0",
               first, second - first, bad);
    end
    tick();
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_vec(0, 0, 0, 0);
    test_reset();
    test_basic();
    test_overflow();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/my_sum_sched.md
MY_SUM_SCHED -- requirements
Module: my_sum_sched

Interface
REQ-001 SHALL have parameter IN_BITS, default 8, signed width of each input term.
REQ-002 SHALL have parameter IN_TERMS, default 4, number of terms per operand vector.
REQ-003 SHALL have parameter CHUNK, default 2, terms summed per cycle; IN_TERMS % CHUNK == 0 is required, and elaboration fails otherwise.
REQ-004 SHALL have parameter OUT_BITS, default 8, signed width of the result.
REQ-005 One clock; reset is synchronous and active-low.
REQ-006 Port: clk  input  1  rising-edge clock.
REQ-007 Port: rst_n  input  1  synchronous active-low reset.
REQ-008 Port: in  input  signed [IN_BITS-1:0] x [IN_TERMS]  operand vector.
REQ-009 Port: in_valid  input  1  operand vector valid.
REQ-010 Port: in_ready  output  1  block can accept a vector.
REQ-011 Port: out  output  signed [OUT_BITS-1:0]  sum result.
REQ-012 Port: out_valid  output  1  result valid.
REQ-013 Port: out_ready  input  1  consumer accepts result.
REQ-014 Port: busy  output  1  high in ACCUM or DONE.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM, DONE; NCHUNK = IN_TERMS/CHUNK.
REQ-016 IDLE: in_ready=1; on in_valid&&in_ready the block SHALL register the whole vector, clear acc, set the chunk index to 0, and go to ACCUM.
REQ-017 ACCUM: each cycle, acc SHALL be incremented by the sum of terms [idx*CHUNK .. idx*CHUNK+CHUNK-1], and idx SHALL increment by 1; after the chunk with idx==NCHUNK-1, the FSM SHALL go to DONE.
REQ-018 Internal acc width SHALL be ACC_BITS = IN_BITS + clog2(IN_TERMS); the accumulation itself SHALL never overflow.
REQ-019 out_valid SHALL rise exactly NCHUNK cycles after the accepting edge and SHALL stay high in DONE only.
REQ-020 DONE: out SHALL be held stable until out_valid&&out_ready, after which the FSM SHALL go to IDLE on that edge.
REQ-021 in_ready SHALL be 0 in ACCUM and DONE, including in the cycle where out_ready is high; back-to-back throughput SHALL be one vector per NCHUNK+2 cycles.
REQ-022 Changes on the in port after acceptance SHALL NOT affect the result in flight.
REQ-023 in_valid while busy SHALL be ignored, with no state change.
REQ-024 out SHALL be 0 whenever out_valid=0.

Reset
REQ-025 On rst_n==0 at a clock edge: state=IDLE, acc=0, idx=0, out=0, out_valid=0, busy=0, in_ready=1 after the edge.
REQ-026 Reset SHALL take priority over every handshake; a vector in ACCUM or DONE SHALL be discarded with no partial output.

Configuration
REQ-027 Macro MY_SUM_SCHED_SAT_EN defined: out SHALL be acc clamped to [-2^(OUT_BITS-1), 2^(OUT_BITS-1)-1].
REQ-028 Macro MY_SUM_SCHED_SAT_EN defined: an extra output port out_sat (1 bit) SHALL be high with out_valid when a clamp occurred, and 0 at reset.
REQ-029 Macro MY_SUM_SCHED_SAT_EN undefined: out SHALL be acc[OUT_BITS-1:0] (two's-complement wrap), and the out_sat port SHALL be absent.

Structure
REQ-030 The state enum (IDLE/ACCUM/DONE) and the ACC_BITS helper function SHALL live in shared package my_sum_pkg.
REQ-031 The per-cycle chunk sum SHALL be one instance of the existing combinational summer my_sum (in_bits=IN_BITS, in_terms=CHUNK, out_bits=ACC_BITS); there SHALL be no other sub-modules.

Verification (IN_BITS=8, IN_TERMS=4, CHUNK=2, OUT_BITS=8)
REQ-032 {10,20,30,40}, out_ready=1 -> out=100 with out_valid high 2 cycles after accept, then in_ready=1 one cycle later.
REQ-033 {100,100,100,100} -> without macro out=-112; with macro out=127 and out_sat=1.
REQ-034 {-128,-128,-128,-128} -> without macro out=0; with macro out=-128 and out_sat=1.
REQ-035 out_ready held 0 for 5 cycles in DONE, with a new vector driven -> out stable, in_ready=0, second vector not accepted until after the handshake.
REQ-036 rst_n low for 1 cycle during ACCUM -> next cycle IDLE, out_valid=0, out=0; a subsequent {1,2,3,4} yields out=10.
